out_port_arb: RTL and testbench

OUT_PORT_ARB -- requirements
Module: out_port_arb

---
 rtl/out_port_arb.sv | 118 +++++++++++
 tb/tb_out_port_arb.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/out_port_arb.sv
// out_port_arb: credit-gated round-robin arbiter for one router output port.
// Five requesters (N,S,E,W,L) compete for a single output; a grant is issued
// only while the downstream buffer has a free slot. Grants are registered and
// appear one cycle after the request is sampled.
// Optional build macro OUT_ARB_CREDIT_CHK_EN: enables the sticky credit
// overflow flag on err_o. Without it err_o is tied low.
module out_port_arb #(
   parameter int unsigned CREDITS = 4,
   parameter int unsigned CW      = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [4:0]    req_i,
   input  logic          incr_i,
   output logic [4:0]    grant_o,
   output logic          valid_o,
   output logic [CW-1:0] credits_o,
   output logic          err_o
);

   localparam int unsigned NUM_PORTS = 5;
   localparam int unsigned PTR_W     = 3;
   localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_PORTS - 1);
   localparam logic [CW-1:0]    CNT_MAX = CW'(CREDITS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_STALL = 2'd2
   } state_t;

   state_t                 state;
   logic [PTR_W-1:0]       ptr;
   logic [CW-1:0]          cnt;
   logic [NUM_PORTS-1:0]   grant_q;

   logic                   grant_issue;
   logic [PTR_W-1:0]       win_idx;
   logic [PTR_W-1:0]       cand;
   logic                   found;
   logic [NUM_PORTS-1:0]   win_onehot;
   logic [CW-1:0]          cnt_next;

   // A grant needs a request and a credit that was already registered.
   assign grant_issue = (|req_i) && (cnt != '0);

   // Round-robin search starting one above the last winner.
   always_comb begin
      win_idx = ptr;
      cand    = '0;
      found   = 1'b0;
      for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
         cand = PTR_W'((32'(ptr) + i) % NUM_PORTS);
         if (!found && req_i[cand]) begin
            found   = 1'b1;
            win_idx = cand;
         end
      end
   end

   assign win_onehot = {{(NUM_PORTS - 1){1'b0}}, 1'b1} << win_idx;

   // Credit counter: consume on grant, return on incr_i, saturate at CREDITS.
   always_comb begin
      cnt_next = cnt;
      if (grant_issue && !incr_i) begin
         cnt_next = cnt - CW'(1);
      end else if (!grant_issue && incr_i && (cnt != CNT_MAX)) begin
         cnt_next = cnt + CW'(1);
      end
   end

   // Arbitration state, pointer, credit count and registered grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         ptr     <= PTR_RST;
         cnt     <= CNT_MAX;
         grant_q <= '0;
      end else begin
         cnt <= cnt_next;
         if (grant_issue) begin
            state   <= S_GRANT;
            ptr     <= win_idx;
            grant_q <= win_onehot;
         end else begin
            grant_q <= '0;
            state   <= (|req_i) ? S_STALL : S_IDLE;
         end
      end
   end

   assign grant_o   = grant_q;
   assign valid_o   = (state == S_GRANT);
   assign credits_o = cnt;

`ifdef OUT_ARB_CREDIT_CHK_EN
   logic overflow;
   logic err_q;

   // A credit returned while already full with nothing consumed is an overflow.
   assign overflow = incr_i && !grant_issue && (cnt == CNT_MAX);

   // Sticky overflow flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (overflow) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_out_port_arb.sv
// Directed bench for out_port_arb (CREDITS=4, CW=4).
module tb_out_port_arb;

   logic       clk;
   logic       rst;
   logic [4:0] req_i;
   logic       incr_i;
   logic [4:0] grant_o;
   logic       valid_o;
   logic [3:0] credits_o;
   logic       err_o;

   int checks = 0;
   int errors = 0;

`ifdef OUT_ARB_CREDIT_CHK_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   out_port_arb #(.CREDITS(4), .CW(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req_i),
      .incr_i    (incr_i),
      .grant_o   (grant_o),
      .valid_o   (valid_o),
      .credits_o (credits_o),
      .err_o     (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst    = 1'b0;
      req_i  = '0;
      incr_i = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      req_i  = '0;
      incr_i = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      checks++; if (grant_o !== 5'b00000) begin errors++; $display("FAIL reset_grant got %b exp %b", grant_o, 5'b00000); end
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
      checks++; if (credits_o !== 4'd4) begin errors++; $display("FAIL reset_credits got %0d exp 4", credits_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_o); end
      tick();
      rst = 1'b1;
      tick();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got %b exp 0", valid_o); end
   endtask

   task automatic test_round_robin();
      logic [4:0] exp_seq [6];
      exp_seq[0] = 5'b00010; exp_seq[1] = 5'b00100; exp_seq[2] = 5'b01000;
      exp_seq[3] = 5'b10000; exp_seq[4] = 5'b00001; exp_seq[5] = 5'b00010;
      apply_reset();
      req_i = 5'b11111;
      tick();
      checks++; if (grant_o !== 5'b00001) begin errors++; $display("FAIL rr_first got %b exp %b", grant_o, 5'b00001); end
      checks++; if (credits_o !== 4'd3) begin errors++; $display("FAIL rr_first_credits got %0d exp 3", credits_o); end
      incr_i = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++; if (grant_o !== exp_seq[k]) begin errors++; $display("FAIL rr_seq%0d got %b exp %b", k, grant_o, exp_seq[k]); end
         checks++; if (credits_o !== 4'd3) begin errors++; $display("FAIL rr_credits%0d got %0d exp 3", k, credits_o); end
      end
      req_i  = '0;
      incr_i = 1'b0;
      tick();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rr_idle_valid got %b exp 0", valid_o); end
      checks++; if (credits_o !== 4'd3) begin errors++; $display("FAIL rr_idle_credits got %0d exp 3", credits_o); end
   endtask

   task automatic test_single_and_stall();
      apply_reset();
      req_i = 5'b00001;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++; if (grant_o !== 5'b00001) begin errors++; $display("FAIL single_grant%0d got %b exp %b", k, grant_o, 5'b00001); end
         checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL single_valid%0d got %b exp 1", k, valid_o); end
         checks++; if (credits_o !== 4'(4 - k)) begin errors++; $display("FAIL single_credits%0d got %0d exp %0d", k, credits_o, 4 - k); end
      end
      tick();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL stall_valid got %b exp 0", valid_o); end
      checks++; if (grant_o !== 5'b00000) begin errors++; $display("FAIL stall_grant got %b exp %b", grant_o, 5'b00000); end
      checks++; if (credits_o !== 4'd0) begin errors++; $display("FAIL stall_credits got %0d exp 0", credits_o); end

      // Stall release: credit at cycle t, grant visible at t+2.
      req_i = 5'b00100;
      tick();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL release_pre_valid got %b exp 0", valid_o); end
      incr_i = 1'b1;
      tick();
      incr_i = 1'b0;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL release_t1_valid got %b exp 0", valid_o); end
      checks++; if (credits_o !== 4'd1) begin errors++; $display("FAIL release_t1_credits got %0d exp 1", credits_o); end
      tick();
      checks++; if (grant_o !== 5'b00100) begin errors++; $display("FAIL release_t2_grant got %b exp %b", grant_o, 5'b00100); end
      checks++; if (credits_o !== 4'd0) begin errors++; $display("FAIL release_t2_credits got %0d exp 0", credits_o); end
      tick();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL release_t3_valid got %b exp 0", valid_o); end
      req_i = '0;
   endtask

   task automatic test_overflow();
      apply_reset();
      incr_i = 1'b1;
      tick();
      incr_i = 1'b0;
      checks++; if (credits_o !== 4'd4) begin errors++; $display("FAIL ovf_credits got %0d exp 4", credits_o); end
      checks++; if (err_o !== ERR_EXP) begin errors++; $display("FAIL ovf_err got %b exp %b", err_o, ERR_EXP); end
      tick();
      checks++; if (err_o !== ERR_EXP) begin errors++; $display("FAIL ovf_err_sticky got %b exp %b", err_o, ERR_EXP); end
      checks++; if (credits_o !== 4'd4) begin errors++; $display("FAIL ovf_credits_hold got %0d exp 4", credits_o); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      req_i = 5'b10010;
      tick();
      checks++; if (grant_o !== 5'b00010) begin errors++; $display("FAIL mid_g1 got %b exp %b", grant_o, 5'b00010); end
      tick();
      checks++; if (grant_o !== 5'b10000) begin errors++; $display("FAIL mid_g2 got %b exp %b", grant_o, 5'b10000); end
      // Request change between edges must not reach grant_o.
      req_i = 5'b00001;
      #1;
      checks++; if (grant_o !== 5'b10000) begin errors++; $display("FAIL mid_comb_path got %b exp %b", grant_o, 5'b10000); end
      req_i = 5'b10010;
      rst = 1'b0;
      #1;
      checks++; if (grant_o !== 5'b00000) begin errors++; $display("FAIL mid_rst_grant got %b exp %b", grant_o, 5'b00000); end
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", valid_o); end
      checks++; if (credits_o !== 4'd4) begin errors++; $display("FAIL mid_rst_credits got %0d exp 4", credits_o); end
      tick();
      rst = 1'b1;
      tick();
      checks++; if (grant_o !== 5'b00010) begin errors++; $display("FAIL mid_after_grant got %b exp %b", grant_o, 5'b00010); end
      checks++; if (credits_o !== 4'd3) begin errors++; $display("FAIL mid_after_credits got %0d exp 3", credits_o); end
      req_i = '0;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single_and_stall();
      test_overflow();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
